prog_seq_detect: RTL and testbench
==================================

PROG_SEQ_DETECT -- requirements
Module: prog_seq_detect

Interface
REQ-001 SHALL have parameter PAT_W, default 5: pattern length in bits, legal range 2..16.
REQ-002 SHALL have parameter CNT_W, default 8: match counter width.
REQ-003 SHALL have parameter DEF_PAT, default 5'b10110: pattern value loaded at reset.
REQ-004 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port din, input, 1: serial data bit.
REQ-007 SHALL have port din_valid, input, 1: din is sampled only when high.
REQ-008 SHALL have port overlap, input, 1: 1 = overlapping detection; 0 = non-overlapping detection.
REQ-009 SHALL have port pat_load, input, 1: load pat_in as the new pattern.
REQ-010 SHALL have port pat_in, input, PAT_W: new pattern, MSB first in time.
REQ-011 SHALL have port cnt_clr, input, 1: synchronous clear of match_cnt and cnt_sat.
REQ-012 SHALL have port flag, output, 1: registered match pulse.
REQ-013 SHALL have port match_cnt, output, CNT_W: number of matches since reset or clear.
REQ-014 SHALL have port cnt_sat, output, 1: high while match_cnt is saturated.

Function
REQ-015 SHALL keep a PAT_W-bit history shift register; each valid bit shifts in at the LSB, so the oldest bit sits at the MSB.
REQ-016 SHALL keep a fill counter (0..PAT_W, saturating) of valid bits accepted since reset, pattern load, or a non-overlap match.
REQ-017 SHALL set flag=1 on the edge that samples a valid bit when the updated history equals the pattern and the updated fill equals PAT_W; otherwise flag=0 on that edge.
REQ-018 Flag timing SHALL be: latency of one edge, with flag high for exactly one cycle per match.
REQ-019 With din_valid=0, history and fill SHALL hold and flag SHALL be 0.
REQ-020 When overlap=1, history and fill SHALL be kept after a match, so the pattern's trailing bits can start the next match.
REQ-021 When overlap=0, fill SHALL be cleared to 0 on the match edge, so the next match needs PAT_W fresh bits.
REQ-022 overlap SHALL be sampled per edge; changing it mid-stream affects only matches from the next edge on.
REQ-023 On pat_load=1, the pattern register SHALL take pat_in, history and fill SHALL clear to 0, and flag SHALL be 0.
REQ-024 pat_load SHALL take priority over din_valid in the same cycle; that din bit is discarded.
REQ-025 match_cnt SHALL increment on every edge where flag is set, saturating at 2^CNT_W-1.
REQ-026 cnt_sat SHALL be high exactly when match_cnt equals 2^CNT_W-1.
REQ-027 cnt_clr SHALL zero match_cnt and cnt_sat.
REQ-028 If cnt_clr and a match occur on the same edge, match_cnt SHALL become 1.
REQ-029 pat_load SHALL NOT affect match_cnt.

Reset
REQ-030 While rst_n=0, the block SHALL asynchronously drive: flag=0, match_cnt=0, cnt_sat=0, history=0, fill=0, pattern=DEF_PAT.
REQ-031 After rst_n deasserts, the first valid bit SHALL be sampled at the first rising edge.
REQ-032 A reset asserted mid-pattern SHALL discard partial history; a full PAT_W fresh bits are needed before any match.

Structure
REQ-033 The shared include seq_detect_defs.vh SHALL hold the default PAT_W, CNT_W and DEF_PAT constants.
REQ-034 The saturating match counter SHALL be one sub-module, sat_counter (parameter W; inputs inc, clr), instantiated once.
REQ-035 All other logic, including history, fill, pattern and flag, SHALL sit in prog_seq_detect.

Verification (PAT_W=4, pattern 4'b1011 via pat_load, din_valid=1 unless stated)
REQ-036 Overlap=1, bits 1,0,1,1,0,1,1 SHALL produce flag pulses after the 4th and 7th bits, and match_cnt=2.
REQ-037 Overlap=0, the same bits SHALL produce a flag pulse only after the 4th bit, and match_cnt=1.
REQ-038 Bits 1,0 then din_valid=0 for 3 cycles (din toggling), then bits 1,1 SHALL produce one flag pulse one edge after the final bit.
REQ-039 Bits 1,0,1, then pat_load=4'b0110 with din_valid=1 in the same cycle, then bits 0,1,1,0 SHALL produce no flag before the load and one flag after the 4th post-load bit.
REQ-040 CNT_W=2 with 5 matches SHALL leave match_cnt=3 and cnt_sat=1; a following cnt_clr SHALL give match_cnt=0 and cnt_sat=0.
REQ-041 rst_n pulsed low after bits 1,0,1, then bits 1,0,1,1, SHALL produce flag=0, match_cnt=0 and pattern=DEF_PAT immediately, with no flag from the stale bits.

Source files
------------

// File: rtl/prog_seq_detect_pkg.sv
// Shared types, defaults and helpers for prog_seq_detect.
package prog_seq_detect_pkg;
`include "seq_detect_defs.vh"

    localparam int unsigned           DEF_PAT_W   = `SEQ_DETECT_PAT_W;
    localparam int unsigned           DEF_CNT_W   = `SEQ_DETECT_CNT_W;
    localparam logic [DEF_PAT_W-1:0]  DEF_PAT_VAL = `SEQ_DETECT_DEF_PAT;

    // What the datapath does on a given edge; load outranks a valid bit.
    typedef enum logic [1:0] {
        ACT_HOLD  = 2'd0,
        ACT_SHIFT = 2'd1,
        ACT_LOAD  = 2'd2
    } seq_act_e;

    // Bits needed to hold a fill count of 0..pat_w inclusive.
    function automatic int fill_width(input int pat_w);
        return $clog2(pat_w + 1);
    endfunction

endpackage

// File: rtl/prog_seq_detect_sat_counter.sv
// Saturating up-counter with synchronous clear; clear plus increment lands on 1.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt,
    output logic         sat
);

    localparam logic [W-1:0] CNT_MAX = {W{1'b1}};

    logic [W-1:0] r_cnt;
    logic         r_sat;
    logic [W-1:0] w_cnt_nxt;

    // Next count: clear wins, but a coincident increment still counts once.
    always_comb begin
        w_cnt_nxt = r_cnt;
        if (clr) begin
            w_cnt_nxt = inc ? W'(1) : {W{1'b0}};
        end else if (inc && (r_cnt != CNT_MAX)) begin
            w_cnt_nxt = r_cnt + W'(1);
        end else begin
            w_cnt_nxt = r_cnt;
        end
    end

    // Count and saturation flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= {W{1'b0}};
            r_sat <= 1'b0;
        end else begin
            r_cnt <= w_cnt_nxt;
            r_sat <= (w_cnt_nxt == CNT_MAX);
        end
    end

    assign cnt = r_cnt;
    assign sat = r_sat;

endmodule

// File: rtl/seq_detect_defs.vh
// Default build constants for the programmable sequence detector.
`ifndef SEQ_DETECT_DEFS_VH
`define SEQ_DETECT_DEFS_VH
`define SEQ_DETECT_PAT_W   5
`define SEQ_DETECT_CNT_W   8
`define SEQ_DETECT_DEF_PAT 5'b10110
`endif

// File: rtl/prog_seq_detect.sv
// Serial pattern detector with a runtime-loadable pattern, overlap control
// and a saturating match counter.
module prog_seq_detect
    import prog_seq_detect_pkg::*;
#(
    parameter int               PAT_W   = DEF_PAT_W,
    parameter int               CNT_W   = DEF_CNT_W,
    parameter logic [PAT_W-1:0] DEF_PAT = PAT_W'(DEF_PAT_VAL)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             din,
    input  logic             din_valid,
    input  logic             overlap,
    input  logic             pat_load,
    input  logic [PAT_W-1:0] pat_in,
    input  logic             cnt_clr,
    output logic             flag,
    output logic [CNT_W-1:0] match_cnt,
    output logic             cnt_sat
);

    localparam int               FILL_W    = fill_width(PAT_W);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

    logic [PAT_W-1:0]  r_pat;
    logic [PAT_W-1:0]  r_hist;
    logic [FILL_W-1:0] r_fill;
    logic              r_flag;

    seq_act_e          w_act;
    logic [PAT_W-1:0]  w_hist_shift;
    logic [FILL_W-1:0] w_fill_inc;
    logic [PAT_W-1:0]  w_pat_nxt;
    logic [PAT_W-1:0]  w_hist_nxt;
    logic [FILL_W-1:0] w_fill_nxt;
    logic              w_match;

    // Candidate history/fill for an accepted bit, and the edge action.
    always_comb begin
        w_hist_shift = {r_hist[PAT_W-2:0], din};
        if (r_fill == FILL_FULL) begin
            w_fill_inc = r_fill;
        end else begin
            w_fill_inc = r_fill + FILL_W'(1);
        end
        if (pat_load) begin
            w_act = ACT_LOAD;
        end else if (din_valid) begin
            w_act = ACT_SHIFT;
        end else begin
            w_act = ACT_HOLD;
        end
    end

    // Next-state selection; a non-overlap match restarts the fill count.
    always_comb begin
        w_pat_nxt  = r_pat;
        w_hist_nxt = r_hist;
        w_fill_nxt = r_fill;
        w_match    = 1'b0;
        case (w_act)
            ACT_LOAD: begin
                w_pat_nxt  = pat_in;
                w_hist_nxt = {PAT_W{1'b0}};
                w_fill_nxt = {FILL_W{1'b0}};
            end
            ACT_SHIFT: begin
                w_hist_nxt = w_hist_shift;
                w_match    = (w_hist_shift == r_pat) && (w_fill_inc == FILL_FULL);
                w_fill_nxt = (w_match && !overlap) ? {FILL_W{1'b0}} : w_fill_inc;
            end
            default: begin
                w_pat_nxt  = r_pat;
                w_hist_nxt = r_hist;
                w_fill_nxt = r_fill;
            end
        endcase
    end

    // Pattern, history, fill and flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pat  <= DEF_PAT;
            r_hist <= {PAT_W{1'b0}};
            r_fill <= {FILL_W{1'b0}};
            r_flag <= 1'b0;
        end else begin
            r_pat  <= w_pat_nxt;
            r_hist <= w_hist_nxt;
            r_fill <= w_fill_nxt;
            r_flag <= w_match;
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_sat_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_match),
        .clr   (cnt_clr),
        .cnt   (match_cnt),
        .sat   (cnt_sat)
    );

    assign flag = r_flag;

endmodule

// File: tb/tb_prog_seq_detect.sv
// Scoreboard bench for prog_seq_detect (PAT_W=4, CNT_W=2) with a queue-based reference model.
module tb_prog_seq_detect;

    localparam int         PW   = 4;
    localparam int         CW   = 2;
    localparam int         CMAX = 3;
    localparam logic [3:0] DEFP = 4'b1011;

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b0;
    logic       din       = 1'b0;
    logic       din_valid = 1'b0;
    logic       overlap   = 1'b0;
    logic       pat_load  = 1'b0;
    logic [3:0] pat_in    = 4'b0000;
    logic       cnt_clr   = 1'b0;
    logic       flag;
    logic [1:0] match_cnt;
    logic       cnt_sat;

    prog_seq_detect #(
        .PAT_W   (PW),
        .CNT_W   (CW),
        .DEF_PAT (DEFP)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .din       (din),
        .din_valid (din_valid),
        .overlap   (overlap),
        .pat_load  (pat_load),
        .pat_in    (pat_in),
        .cnt_clr   (cnt_clr),
        .flag      (flag),
        .match_cnt (match_cnt),
        .cnt_sat   (cnt_sat)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       flag;
        logic [1:0] cnt;
        logic       sat;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model: the bits seen since the last restart, plus pattern and count.
    logic [3:0] m_pat;
    bit         m_hist[$];
    int         m_cnt;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pat = DEFP;
        m_hist.delete();
        m_cnt = 0;
    endtask

    // One clock of stimulus; the model's post-edge expectation goes to the scoreboard.
    task automatic step(input logic v, input logic d, input logic ov, input logic ld,
                        input logic [3:0] pin, input logic clr);
        bit   match;
        int   val;
        exp_t e;
        din_valid = v;
        din       = d;
        overlap   = ov;
        pat_load  = ld;
        pat_in    = pin;
        cnt_clr   = clr;
        @(posedge clk);
        match = 1'b0;
        if (ld) begin
            m_pat = pin;
            m_hist.delete();
        end else if (v) begin
            m_hist.push_back(bit'(d));
            if (m_hist.size() > PW) void'(m_hist.pop_front());
            if (m_hist.size() == PW) begin
                val = 0;
                foreach (m_hist[i]) val = val * 2 + int'(m_hist[i]);
                match = (val == int'(m_pat));
            end
            if (match && !ov) m_hist.delete();
        end
        if (clr) m_cnt = match ? 1 : 0;
        else if (match && m_cnt < CMAX) m_cnt++;
        e.flag = match;
        e.cnt  = 2'(m_cnt);
        e.sat  = (m_cnt == CMAX);
        sb_q.push_back(e);
        #1;
    endtask

    task automatic send_seq(input logic ov, input logic [15:0] seq, input int n);
        for (int i = n - 1; i >= 0; i--) step(1'b1, seq[i], ov, 1'b0, 4'b0000, 1'b0);
    endtask

    task automatic load(input logic [3:0] p);
        step(1'b0, 1'b0, overlap, 1'b1, p, 1'b1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        rst_n     = 1'b0;
        din_valid = 1'b0;
        pat_load  = 1'b0;
        cnt_clr   = 1'b0;
        #2;
        check("rst_flag", int'(flag), 0);
        check("rst_cnt", int'(match_cnt), 0);
        check("rst_sat", int'(cnt_sat), 0);
        model_reset();
        sb_q.delete();
        @(negedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Monitor: compare every presented output cycle against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            check("sb_flag", int'(flag), int'(mon_e.flag));
            check("sb_cnt", int'(match_cnt), int'(mon_e.cnt));
            check("sb_sat", int'(cnt_sat), int'(mon_e.sat));
        end
    end

    initial begin
        logic ov_r;
        model_reset();
        #2;
        check("init_flag", int'(flag), 0);
        check("init_cnt", int'(match_cnt), 0);
        check("init_sat", int'(cnt_sat), 0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;

        // Load with din_valid high: the bit must be discarded.
        step(1'b1, 1'b1, 1'b1, 1'b1, 4'b1011, 1'b1);
        send_seq(1'b1, 16'b1011011, 7);
        check("ovl_cnt", int'(match_cnt), 2);

        load(4'b1011);
        send_seq(1'b0, 16'b1011011, 7);
        check("novl_cnt", int'(match_cnt), 1);

        load(4'b1011);
        send_seq(1'b0, 16'b10, 2);
        for (int i = 0; i < 3; i++) step(1'b0, 1'(i % 2), 1'b0, 1'b0, 4'b0000, 1'b0);
        send_seq(1'b0, 16'b11, 2);
        check("gap_flag", int'(flag), 1);

        load(4'b1011);
        send_seq(1'b0, 16'b101, 3);
        step(1'b1, 1'b1, 1'b0, 1'b1, 4'b0110, 1'b0);
        send_seq(1'b0, 16'b0110, 4);
        check("reload_flag", int'(flag), 1);

        load(4'b1011);
        send_seq(1'b1, 16'b1011011011011011, 16);
        check("sat_cnt", int'(match_cnt), 3);
        check("sat_flag", int'(cnt_sat), 1);
        step(1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b1);
        check("clr_cnt", int'(match_cnt), 0);
        check("clr_sat", int'(cnt_sat), 0);

        ov_r = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(7, 0) == 0) ov_r = ~ov_r;
            step(($urandom_range(3, 0) != 0), 1'($urandom_range(1, 0)), ov_r,
                 ($urandom_range(39, 0) == 0), 4'($urandom_range(15, 0)),
                 ($urandom_range(29, 0) == 0));
        end

        load(4'b0101);
        send_seq(1'b1, 16'b101, 3);
        do_reset();
        send_seq(1'b1, 16'b1011, 4);
        check("post_rst_flag", int'(flag), 1);
        check("post_rst_cnt", int'(match_cnt), 1);

        step(1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0);
        repeat (2) @(negedge clk);
        #1;
        check("sb_drain", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
